spi_byte_engine: RTL and testbench

//   Full-duplex SPI master byte engine: built-in clock divider plus byte shifter (mode 0, MSB first).

---
 rtl/spi_byte_engine_if.sv | 22 ++
 rtl/spi_byte_engine.sv | 117 +++++++++++
 tb/tb_spi_byte_engine.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_engine_if.sv
// Controller-facing signal bundle of the SPI byte engine.
// The engine takes the slave modport; the SD controller (or a bench) takes master.
interface spi_byte_engine_if;
  logic       SPI_Enable;
  logic       SpeedSel;
  logic [7:0] OutputData;
  logic       SPI_MISO;
  logic       SPI_MOSI;
  logic       SPI_CLK;
  logic [7:0] InputData;
  logic       DataClk;

  modport master (
    output SPI_Enable, SpeedSel, OutputData, SPI_MISO,
    input  SPI_MOSI, SPI_CLK, InputData, DataClk
  );

  modport slave (
    input  SPI_Enable, SpeedSel, OutputData, SPI_MISO,
    output SPI_MOSI, SPI_CLK, InputData, DataClk
  );
endinterface

// File: rtl/spi_byte_engine.sv
// Full-duplex SPI master byte engine, mode 0, MSB first, with a two-rate clock divider.
// Bytes stream back-to-back while enabled; DataClk strobes once per received byte.
module spi_byte_engine #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned INIT_FREQ = 400000,
  parameter int unsigned WORK_FREQ = 10000000
) (
  input logic              MasterCLK,
  input logic              Reset,
  spi_byte_engine_if.slave bus
);

  localparam int unsigned HalfInit = CLK_FREQ / (2 * INIT_FREQ);
  localparam int unsigned HalfWork = CLK_FREQ / (2 * WORK_FREQ);
  localparam int unsigned HalfMax  = (HalfInit > HalfWork) ? HalfInit : HalfWork;
  localparam int unsigned DivW     = $clog2(HalfMax + 1);

  if (HalfInit < 2 || HalfWork < 2) begin : gBadDivider
    $error("spi_byte_engine: half-period count must be at least 2");
  end

  logic [DivW-1:0] divCnt,      divCntNext;
  logic [DivW-1:0] halfN,       halfNNext;
  logic [2:0]      bitCnt,      bitCntNext;
  logic [7:0]      txShift,     txShiftNext;
  logic [7:0]      rxShift,     rxShiftNext;
  logic            spiClk,      spiClkNext;
  logic            mosi,        mosiNext;
  logic [7:0]      inputData,   inputDataNext;
  logic            dataClk,     dataClkNext;
  logic            donePending, donePendingNext;
  logic [DivW-1:0] speedHalf;
  logic            tick;

  assign speedHalf = bus.SpeedSel ? DivW'(HalfWork) : DivW'(HalfInit);

  // Next-state logic: divider, SPI clock phase, shifters and byte strobe.
  always_comb begin
    divCntNext      = divCnt;
    halfNNext       = halfN;
    bitCntNext      = bitCnt;
    txShiftNext     = txShift;
    rxShiftNext     = rxShift;
    spiClkNext      = spiClk;
    mosiNext        = mosi;
    donePendingNext = 1'b0;
    tick            = 1'b0;

    if (!bus.SPI_Enable) begin
      divCntNext  = '0;
      halfNNext   = speedHalf;
      bitCntNext  = '0;
      txShiftNext = bus.OutputData;
      rxShiftNext = '0;
      spiClkNext  = 1'b0;
      mosiNext    = 1'b1;
    end else begin
      tick = (divCnt == halfN - DivW'(1));
      if (tick) begin
        divCntNext = '0;
        spiClkNext = ~spiClk;
        if (!spiClk) begin
          rxShiftNext     = {rxShift[6:0], bus.SPI_MISO};
          donePendingNext = (bitCnt == 3'd7);
        end else begin
          bitCntNext = bitCnt + 3'd1;
          // Last falling edge of a byte doubles as the next-byte load point.
          if (bitCnt == 3'd7) begin
            txShiftNext = bus.OutputData;
            halfNNext   = speedHalf;
          end else begin
            txShiftNext = {txShift[6:0], 1'b0};
          end
        end
      end else begin
        divCntNext = divCnt + DivW'(1);
      end
      mosiNext = txShiftNext[7];
    end

    // Byte completes one cycle after the 8th rising edge; an abort in between suppresses it.
    dataClkNext   = donePending && bus.SPI_Enable;
    inputDataNext = dataClkNext ? rxShift : inputData;
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      divCnt      <= '0;
      halfN       <= DivW'(HalfInit);
      bitCnt      <= '0;
      txShift     <= '0;
      rxShift     <= '0;
      spiClk      <= 1'b0;
      mosi        <= 1'b1;
      inputData   <= 8'hFF;
      dataClk     <= 1'b0;
      donePending <= 1'b0;
    end else begin
      divCnt      <= divCntNext;
      halfN       <= halfNNext;
      bitCnt      <= bitCntNext;
      txShift     <= txShiftNext;
      rxShift     <= rxShiftNext;
      spiClk      <= spiClkNext;
      mosi        <= mosiNext;
      inputData   <= inputDataNext;
      dataClk     <= dataClkNext;
      donePending <= donePendingNext;
    end
  end

  assign bus.SPI_CLK   = spiClk;
  assign bus.SPI_MOSI  = mosi;
  assign bus.InputData = inputData;
  assign bus.DataClk   = dataClk;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: slave model on MISO, scoreboard of expected
// received/transmitted bytes and strobe spacing, checked on every DataClk.
module tb_spi_byte_engine;

  localparam int NInit = 125;
  localparam int NWork = 5;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         gap;
  } exp_t;

  logic MasterCLK = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t       q[$];
  logic [7:0] nextSlave = 8'hFF;
  logic [7:0] sCur = 8'hFF;
  int         sBit = 0;
  logic       prevClk = 1'b0;
  logic       lastMosi = 1'b1;
  logic [7:0] mosiByte = 8'h00;
  int         refCyc = 0;

  spi_byte_engine_if bus();

  spi_byte_engine dut (
    .MasterCLK(MasterCLK),
    .Reset    (Reset),
    .bus      (bus)
  );

  always #5 MasterCLK = ~MasterCLK;
  always @(posedge MasterCLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge MasterCLK);
    #2;
  endtask

  task automatic waitStrobe(input string tag, input int maxCyc);
    int n = 0;
    do begin
      step();
      n++;
    end while (bus.DataClk !== 1'b1 && n < maxCyc);
    check(tag, 32'(bus.DataClk), 32'd1);
  endtask

  // Counts cycles until SPI_CLK reaches the given level.
  task automatic waitClk(input logic level, input int maxCyc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.SPI_CLK !== level && n < maxCyc);
  endtask

  task automatic push(input logic [7:0] rx, input logic [7:0] tx, input int gap);
    exp_t e;
    e.rx  = rx;
    e.tx  = tx;
    e.gap = gap;
    q.push_back(e);
  endtask

  // Monitor/scoreboard and mode-0 slave model, evaluated mid-cycle.
  always @(negedge MasterCLK) begin
    if (!Reset) begin
      sBit     = 0;
      sCur     = nextSlave;
      prevClk  = 1'b0;
      lastMosi = 1'b1;
      refCyc   = cyc + 1;
    end else begin
      if (bus.DataClk === 1'b1) begin
        check("strobe_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          check("rx_byte", 32'(bus.InputData), 32'(e.rx));
          check("mosi_byte", 32'(mosiByte), 32'(e.tx));
          check("strobe_gap", 32'(cyc - refCyc), 32'(e.gap));
        end
        refCyc = cyc;
      end
      if (!prevClk && bus.SPI_CLK === 1'b1) begin
        check("mosi_stable", 32'(bus.SPI_MOSI), 32'(lastMosi));
        mosiByte = {mosiByte[6:0], bus.SPI_MOSI};
      end
      if (bus.SPI_Enable !== 1'b1) begin
        sBit   = 0;
        sCur   = nextSlave;
        refCyc = cyc + 1;
      end else if (prevClk && bus.SPI_CLK === 1'b0) begin
        if (sBit == 7) begin
          sBit = 0;
          sCur = nextSlave;
        end else begin
          sBit++;
        end
      end
      prevClk  = bus.SPI_CLK;
      lastMosi = bus.SPI_MOSI;
    end
    bus.SPI_MISO = sCur[3'(7 - sBit)];
  end

  initial begin
    int n;
    int rises;
    logic pc;

    Reset          = 1'b0;
    bus.SPI_Enable = 1'b0;
    bus.SpeedSel   = 1'b0;
    bus.OutputData = 8'h00;
    repeat (3) step();
    check("rst_spi_clk", 32'(bus.SPI_CLK), 32'd0);
    check("rst_mosi", 32'(bus.SPI_MOSI), 32'd1);
    check("rst_input_data", 32'(bus.InputData), 32'hFF);
    check("rst_data_clk", 32'(bus.DataClk), 32'd0);
    Reset = 1'b1;
    step();

    // Slow-rate single byte, half-period measured directly.
    bus.OutputData = 8'h40;
    nextSlave      = 8'h01;
    step();
    push(8'h01, 8'h40, 15 * NInit + 1);
    bus.SPI_Enable = 1'b1;
    waitClk(1'b1, 1000, n);
    check("first_rise_latency", 32'(n), 32'(NInit));
    waitClk(1'b0, 1000, n);
    check("slow_half_period", 32'(n), 32'(NInit));
    waitStrobe("strobe_byte1", 4000);

    // Back-to-back byte; speed switched mid-byte takes effect only at the next load.
    bus.OutputData = 8'h95;
    nextSlave      = 8'hA5;
    push(8'hA5, 8'h95, 16 * NInit);
    repeat (500) step();
    bus.SpeedSel = 1'b1;
    waitStrobe("strobe_byte2", 4000);
    bus.OutputData = 8'h3C;
    nextSlave      = 8'hC3;
    push(8'hC3, 8'h3C, NInit + 15 * NWork);
    waitStrobe("strobe_byte3", 4000);

    // Fast rate: slave returns FF then 00.
    bus.OutputData = 8'h5A;
    nextSlave      = 8'hFF;
    push(8'hFF, 8'h5A, 16 * NWork);
    waitStrobe("strobe_byte4", 400);
    bus.OutputData = 8'h0F;
    nextSlave      = 8'h00;
    push(8'h00, 8'h0F, 16 * NWork);
    waitStrobe("strobe_byte5", 400);
    bus.SPI_Enable = 1'b0;
    repeat (200) step();
    check("drained_after_fast", 32'(q.size()), 32'd0);

    // Abort after the third rising edge, then a clean re-enabled byte.
    bus.SpeedSel   = 1'b0;
    bus.OutputData = 8'hC6;
    nextSlave      = 8'h5A;
    step();
    bus.SPI_Enable = 1'b1;
    rises = 0;
    pc    = 1'b0;
    n     = 0;
    while (rises < 3 && n < 2000) begin
      step();
      n++;
      if (!pc && bus.SPI_CLK === 1'b1) rises++;
      pc = bus.SPI_CLK;
    end
    check("abort_reached_rise3", 32'(rises), 32'd3);
    bus.SPI_Enable = 1'b0;
    step();
    check("abort_spi_clk", 32'(bus.SPI_CLK), 32'd0);
    check("abort_mosi", 32'(bus.SPI_MOSI), 32'd1);
    check("abort_data_clk", 32'(bus.DataClk), 32'd0);
    check("abort_input_data", 32'(bus.InputData), 32'h00);
    repeat (300) step();
    bus.OutputData = 8'hE7;
    nextSlave      = 8'h7E;
    step();
    push(8'h7E, 8'hE7, 15 * NInit + 1);
    bus.SPI_Enable = 1'b1;
    waitStrobe("strobe_reenable", 4000);
    bus.SPI_Enable = 1'b0;
    repeat (20) step();
    check("drained_after_abort", 32'(q.size()), 32'd0);

    // Asynchronous reset while SPI_CLK is high mid-byte.
    bus.OutputData = 8'h00;
    step();
    bus.SPI_Enable = 1'b1;
    waitClk(1'b1, 1000, n);
    repeat (10) step();
    check("pre_reset_spi_clk", 32'(bus.SPI_CLK), 32'd1);
    Reset = 1'b0;
    #1;
    check("async_rst_spi_clk", 32'(bus.SPI_CLK), 32'd0);
    check("async_rst_mosi", 32'(bus.SPI_MOSI), 32'd1);
    check("async_rst_input_data", 32'(bus.InputData), 32'hFF);
    check("async_rst_data_clk", 32'(bus.DataClk), 32'd0);
    bus.SPI_Enable = 1'b0;
    step();
    Reset = 1'b1;
    repeat (5) step();
    check("final_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
